semaforo_param: RTL and testbench

//  Parametrised two-road traffic-light controller, successor of the fixed-timing semaforo.

---
 rtl/semaforo_pkg.sv | 55 +++++
 rtl/semaforo_btn_sync.sv | 22 ++
 rtl/semaforo_param.sv | 147 ++++++++++++++
 tb/tb_semaforo_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and constants for the parametrised traffic-light controller.
package semaforo_pkg;

    localparam int unsigned LAMP_W = 3;

    // Lamp codes, {red,yellow,green}
    localparam logic [LAMP_W-1:0] LAMP_R   = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_Y   = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_G   = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    // One-hot controller states
    typedef enum logic [6:0] {
        S_AG    = 7'b0000001,
        S_AY    = 7'b0000010,
        S_BG    = 7'b0000100,
        S_BY    = 7'b0001000,
        S_AR    = 7'b0010000,
        S_PED   = 7'b0100000,
        S_FLASH = 7'b1000000
    } state_t;

    // Lamp driver payload
    typedef struct packed {
        logic [LAMP_W-1:0] a;
        logic [LAMP_W-1:0] b;
        logic              walk;
    } lamps_t;

    // Moore output decode; flash_on selects the lit half of the night blink
    function automatic lamps_t lamp_decode(input state_t st, input logic flash_on);
        lamp_decode = '{a: LAMP_R, b: LAMP_R, walk: 1'b0};
        unique case (st)
            S_AG:    lamp_decode.a = LAMP_G;
            S_AY:    lamp_decode.a = LAMP_Y;
            S_BG:    lamp_decode.b = LAMP_G;
            S_BY:    lamp_decode.b = LAMP_Y;
            S_AR:    lamp_decode.walk = 1'b0;
            S_PED:   lamp_decode.walk = 1'b1;
            S_FLASH: begin
                lamp_decode.a = flash_on ? LAMP_Y : LAMP_OFF;
                lamp_decode.b = flash_on ? LAMP_Y : LAMP_OFF;
            end
            default: lamp_decode = '{a: LAMP_R, b: LAMP_R, walk: 1'b0};
        endcase
    endfunction

    function automatic int unsigned max2(input int unsigned x, input int unsigned y);
        max2 = (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/semaforo_btn_sync.sv
// Pedestrian button: two-flop synchroniser followed by a rising-edge detector.
module semaforo_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic bt,
    output logic bt_rise
);

    logic [2:0] sync_q;

    // Shift chain: [0],[1] synchronise, [2] holds the previous synced level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], bt};
        end
    end

    assign bt_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/semaforo_param.sv
// Two-road traffic-light controller with pedestrian phase and night flashing mode.
module semaforo_param
    import semaforo_pkg::*;
#(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned T_GREEN     = 8,
    parameter int unsigned T_MIN_GREEN = 3,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned T_PED       = 5,
    parameter int unsigned T_FLASH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bt,
    input  logic              night,
    output logic [LAMP_W-1:0] A,
    output logic [LAMP_W-1:0] B,
    output logic              walk
);

    localparam int unsigned T_MAX = max2(max2(max2(T_GREEN, T_YELLOW), max2(T_ALLRED, T_PED)),
                                         T_FLASH);

    localparam logic [CNT_W-1:0] G_LAST    = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] MING_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] PED_LAST  = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] F_LAST    = CNT_W'(T_FLASH - 1);

    // Parameter sanity checks at elaboration
    if (T_MIN_GREEN < 1 || T_MIN_GREEN > T_GREEN) begin : g_bad_min_green
        $error("semaforo_param: T_MIN_GREEN must be in 1..T_GREEN");
    end
    if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_PED < 1 || T_FLASH < 1) begin : g_bad_dur
        $error("semaforo_param: all phase durations must be >= 1");
    end
    if ((64'(1) << CNT_W) <= 64'(T_MAX)) begin : g_bad_cnt_w
        $error("semaforo_param: CNT_W too narrow for the longest phase");
    end

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               dir, dir_nxt;
    logic               bt_req, bt_req_nxt;
    logic               flash_on, flash_on_nxt;
    logic               half_end;
    logic               green_done;
    logic               bt_rise;
    lamps_t             lamps_nxt;

    semaforo_btn_sync u_btn_sync (
        .clk     (clk),
        .rst     (rst),
        .bt      (bt),
        .bt_rise (bt_rise)
    );

    // State, counter, request and registered lamp drivers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_AG;
            count    <= '0;
            dir      <= DIR_A;
            bt_req   <= 1'b0;
            flash_on <= 1'b1;
            A        <= LAMP_G;
            B        <= LAMP_R;
            walk     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            dir      <= dir_nxt;
            bt_req   <= bt_req_nxt;
            flash_on <= flash_on_nxt;
            A        <= lamps_nxt.a;
            B        <= lamps_nxt.b;
            walk     <= lamps_nxt.walk;
        end
    end

    // Next-state, counter, request latch and output decode
    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir;
        flash_on_nxt = flash_on;
        bt_req_nxt   = bt_req;
        half_end     = 1'b0;
        green_done   = (count == G_LAST) || (bt_req && (count >= MING_LAST));

        unique case (state)
            S_AG: if (green_done) state_nxt = S_AY;
            S_BG: if (green_done) state_nxt = S_BY;
            S_AY: begin
                if (count == Y_LAST) begin
                    state_nxt = S_AR;
                    dir_nxt   = DIR_B;
                end
            end
            S_BY: begin
                if (count == Y_LAST) begin
                    state_nxt = S_AR;
                    dir_nxt   = DIR_A;
                end
            end
            S_AR: begin
                if (count == AR_LAST) begin
                    if (night) begin
                        state_nxt    = S_FLASH;
                        flash_on_nxt = 1'b1;
                    end else if (bt_req) begin
                        state_nxt = S_PED;
                    end else begin
                        state_nxt = (dir == DIR_A) ? S_AG : S_BG;
                    end
                end
            end
            S_PED: begin
                if (count == PED_LAST) state_nxt = (dir == DIR_A) ? S_AG : S_BG;
            end
            S_FLASH: begin
                if (count == F_LAST) begin
                    half_end = 1'b1;
                    if (flash_on)   flash_on_nxt = 1'b0;
                    else if (night) flash_on_nxt = 1'b1;
                    else            state_nxt    = S_AR;
                end
            end
            default: state_nxt = S_AG;
        endcase

        count_nxt = ((state_nxt != state) || half_end) ? '0 : count + CNT_W'(1);

        // Requests are served by the walk phase; presses during walk or night are dropped
        if (state_nxt == S_PED && state != S_PED) begin
            bt_req_nxt = 1'b0;
        end else if (state == S_FLASH) begin
            bt_req_nxt = 1'b0;
        end else if (bt_rise && state != S_PED) begin
            bt_req_nxt = 1'b1;
        end

        lamps_nxt = lamp_decode(state_nxt, flash_on_nxt);
    end

endmodule

// File: tb/tb_semaforo_param.sv
// Randomised bench for semaforo_param against a phase/elapsed-time reference model.
module tb_semaforo_param;

    localparam int TG = 8, TMG = 3, TY = 2, TAR = 1, TPED = 5, TF = 2;
    localparam int P_AG = 0, P_AY = 1, P_BG = 2, P_BY = 3, P_AR = 4, P_PED = 5, P_FLASH = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       bt;
    logic       night;
    logic [2:0] A, B;
    logic       walk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_ph, m_e;
    bit m_dir_b, m_req, m_on;
    bit h1, h2, h3;

    always #5 clk = ~clk;

    semaforo_param #(
        .CNT_W(4), .T_GREEN(TG), .T_MIN_GREEN(TMG), .T_YELLOW(TY),
        .T_ALLRED(TAR), .T_PED(TPED), .T_FLASH(TF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bt    (bt),
        .night (night),
        .A     (A),
        .B     (B),
        .walk  (walk)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dur(input int ph);
        case (ph)
            P_AG, P_BG: dur = TG;
            P_AY, P_BY: dur = TY;
            P_AR:       dur = TAR;
            P_PED:      dur = TPED;
            default:    dur = TF;
        endcase
    endfunction

    // Expected {A,B,walk} for a phase
    function automatic logic [6:0] expect_lamps(input int ph, input bit on);
        case (ph)
            P_AG:    expect_lamps = {3'b001, 3'b100, 1'b0};
            P_AY:    expect_lamps = {3'b010, 3'b100, 1'b0};
            P_BG:    expect_lamps = {3'b100, 3'b001, 1'b0};
            P_BY:    expect_lamps = {3'b100, 3'b010, 1'b0};
            P_AR:    expect_lamps = {3'b100, 3'b100, 1'b0};
            P_PED:   expect_lamps = {3'b100, 3'b100, 1'b1};
            default: expect_lamps = on ? {3'b010, 3'b010, 1'b0} : 7'b0;
        endcase
    endfunction

    // Reference model: advances one clock of elapsed time per edge
    always @(posedge clk or negedge rst) begin
        int  nph, ne;
        bit  ev, last;
        if (!rst) begin
            m_ph = P_AG; m_e = 0; m_dir_b = 0; m_req = 0; m_on = 1;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            ev   = h2 && !h3;
            last = (m_e == dur(m_ph) - 1);
            nph  = m_ph;
            ne   = m_e + 1;
            case (m_ph)
                P_AG: if (last || (m_req && m_e >= TMG - 1)) nph = P_AY;
                P_BG: if (last || (m_req && m_e >= TMG - 1)) nph = P_BY;
                P_AY: if (last) begin nph = P_AR; m_dir_b = 1; end
                P_BY: if (last) begin nph = P_AR; m_dir_b = 0; end
                P_AR: if (last) begin
                    if (night)      begin nph = P_FLASH; m_on = 1; end
                    else if (m_req) nph = P_PED;
                    else            nph = m_dir_b ? P_BG : P_AG;
                end
                P_PED: if (last) nph = m_dir_b ? P_BG : P_AG;
                default: if (last) begin
                    ne = 0;
                    if (m_on)        m_on = 0;
                    else if (night)  m_on = 1;
                    else             nph = P_AR;
                end
            endcase
            if (nph == P_PED && m_ph != P_PED)          m_req = 0;
            else if (m_ph == P_FLASH && nph != P_FLASH) m_req = 0;
            else if (ev && m_ph != P_PED && m_ph != P_FLASH) m_req = 1;
            if (nph != m_ph) ne = 0;
            m_ph = nph;
            m_e  = ne;
            h3 = h2; h2 = h1; h1 = bt;
        end
    end

    // Per-cycle output and safety checks away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            check_eq("lamps", {A, B, walk}, expect_lamps(m_ph, m_on));
            check_eq("a_onehot", 32'($countones(A) <= 1), 32'd1);
            check_eq("b_onehot", 32'($countones(B) <= 1), 32'd1);
            if (m_ph != P_FLASH)
                check_eq("no_conflict", 32'(A == 3'b100 || B == 3'b100), 32'd1);
            if (walk)
                check_eq("walk_red", 32'(A == 3'b100 && B == 3'b100), 32'd1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the model reaches phase ph with elapsed e (e<0: any)
    task automatic wait_phase(input int ph, input int e, input string tag);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (m_ph == ph && (e < 0 || m_e == e)) found = 1;
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    task automatic press(input int len);
        bt = 1'b1;
        cycles(len);
        bt = 1'b0;
    endtask

    initial begin
        rst = 1'b0; bt = 1'b0; night = 1'b0;
        #23;
        check_eq("rst_A", 32'(A), 32'h1);
        check_eq("rst_B", 32'(B), 32'h4);
        check_eq("rst_walk", 32'(walk), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Plain cycling, two full rounds
        cycles(50);

        // Press early in A green: shortened green then walk
        wait_phase(P_AG, 1, "wait_ag1");
        press(3);
        wait_phase(P_PED, -1, "wait_ped1");
        cycles(25);

        // Press during B yellow, then a second press during walk
        wait_phase(P_BY, 0, "wait_by");
        press(2);
        wait_phase(P_PED, 1, "wait_ped2");
        press(2);
        cycles(30);

        // Night mode entry and exit
        wait_phase(P_AG, 2, "wait_ag_night");
        night = 1'b1;
        wait_phase(P_FLASH, -1, "wait_flash");
        cycles(11);
        night = 1'b0;
        cycles(20);

        // Asynchronous reset in the middle of a walk phase
        wait_phase(P_AG, 0, "wait_ag_rst");
        press(2);
        wait_phase(P_PED, 2, "wait_ped_rst");
        #2 rst = 1'b0;
        #1;
        check_eq("arst_A", 32'(A), 32'h1);
        check_eq("arst_B", 32'(B), 32'h4);
        check_eq("arst_walk", 32'(walk), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cycles(30);

        // Random buttons and night requests
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) bt = ~bt;
            if ($urandom_range(0, 149) == 0) night = ~night;
        end
        night = 1'b0;
        bt = 1'b0;
        cycles(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
